// File: rtl/reservoir_state_update.sv
// reservoir_state_update: rescales 16 Q16.16 multiplier results to Q8.8, hard-tanh clamps them and
// leaks them into a 16-entry Q8.8 reservoir state. Define RES_SAT_COUNT_EN to build the saturation counter.
module reservoir_state_update #(
    parameter int LEAK_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    output logic [3:0]  prod_addr,
    input  logic [31:0] prod_data,
    input  logic [3:0]  state_addr,
    output logic [15:0] state_data,
    output logic        busy,
    output logic        done,
    output logic [4:0]  sat_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [3:0]         addr_q, addr_d, widx_q, widx_d;
    logic [1:0]         vld_q, vld_d;
    logic               done_q, done_d;
    logic [15:0]        rd_q, rd_d;
    logic [15:0]        mem_q [16];
    logic [15:0]        mem_d [16];
    logic               go, unused_lo;
    logic signed [23:0] u;
    logic signed [10:0] u_sat, x_old, diff, delta, x_sum;

    assign go        = (fsm_q == IDLE) && start;
    assign unused_lo = ^prod_data[7:0];
    assign u         = $signed(prod_data[31:8]);
    assign u_sat     = (u > 24'sd256) ? 11'sd256 : (u < -24'sd256) ? -11'sd256 : u[10:0];
    assign x_old     = mem_q[widx_q][10:0];
    assign diff      = u_sat - x_old;
    assign delta     = diff >>> LEAK_SHIFT;
    assign x_sum     = x_old + delta;

    // vld_q[0]: an index was presented this cycle; vld_q[1]: its registered data is on prod_data now
    always_comb begin
        fsm_d  = fsm_q;
        addr_d = addr_q;
        widx_d = widx_q;
        mem_d  = mem_q;
        vld_d  = {vld_q[0], go || (fsm_q == RUN && addr_q != 4'd15)};
        done_d = fsm_q == DONE;
        rd_d   = mem_q[state_addr];
        if (go) begin
            fsm_d  = RUN;
            addr_d = '0;
            widx_d = '0;
        end else if (fsm_q == IDLE && clear) begin
            for (int k = 0; k < 16; k++) mem_d[k] = '0;
        end
        if (fsm_q == RUN && addr_q != 4'd15) addr_d = addr_q + 4'd1;
        if (vld_q[1]) begin
            mem_d[widx_q] = {{5{x_sum[10]}}, x_sum};
            widx_d        = widx_q + 4'd1;
            if (widx_q == 4'd15) fsm_d = DONE;
        end
        if (fsm_q == DONE) fsm_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            addr_q <= '0;
            widx_q <= '0;
            vld_q  <= '0;
            done_q <= 1'b0;
            rd_q   <= '0;
            for (int k = 0; k < 16; k++) mem_q[k] <= '0;
        end else begin
            fsm_q  <= fsm_d;
            addr_q <= addr_d;
            widx_q <= widx_d;
            vld_q  <= vld_d;
            done_q <= done_d;
            rd_q   <= rd_d;
            mem_q  <= mem_d;
        end
    end

`ifdef RES_SAT_COUNT_EN
    logic [4:0] cnt_q, cnt_d, sat_q, sat_d;

    always_comb begin
        cnt_d = go ? 5'd0 : (vld_q[1] && (u > 24'sd256 || u < -24'sd256)) ? cnt_q + 5'd1 : cnt_q;
        sat_d = (fsm_q == DONE) ? cnt_q : sat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign sat_cnt = sat_q;
`else
    assign sat_cnt = '0;
`endif

    assign prod_addr  = addr_q;
    assign state_data = rd_q;
    assign busy       = fsm_q != IDLE;
    assign done       = done_q;
endmodule

// File: tb/tb_reservoir_state_update.sv
// tb_reservoir_state_update: two instances (LEAK_SHIFT 0 and 2) checked every cycle against a
// pass-timeline model, plus literal state/sat/latency expectations from hand arithmetic.
module tb_reservoir_state_update;
`ifdef RES_SAT_COUNT_EN
    localparam bit SATEN = 1'b1;
`else
    localparam bit SATEN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0;
    logic [3:0]  state_addr = '0;
    logic [3:0]  pa0, pa2;
    logic [31:0] pd0 = '0, pd2 = '0;
    logic [15:0] sd0, sd2;
    logic        busy0, busy2, done0, done2;
    logic [4:0]  sat0, sat2;
    logic [31:0] res [16];
    int          n_vec = 0, n_err = 0;

    reservoir_state_update #(.LEAK_SHIFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .prod_addr(pa0), .prod_data(pd0),
        .state_addr(state_addr), .state_data(sd0), .busy(busy0), .done(done0), .sat_cnt(sat0));
    reservoir_state_update #(.LEAK_SHIFT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .prod_addr(pa2), .prod_data(pd2),
        .state_addr(state_addr), .state_data(sd2), .busy(busy2), .done(done2), .sat_cnt(sat2));

    always #5 clk = ~clk;

    // multiplier stand-in: registers result[prod_addr] every edge
    always @(posedge clk) begin
        pd0 <= res[pa0];
        pd2 <= res[pa2];
    end

    // model: k = edges since the accepted start (-1 when no pass has run / after the idle return)
    int k = -1, pa = 0;
    int m [2][16];
    int sc [2], msat [2], rd [2];

    function automatic void mreset();
        k = -1;
        pa = 0;
        for (int j = 0; j < 2; j++) begin
            sc[j] = 0; msat[j] = 0; rd[j] = 0;
            for (int i = 0; i < 16; i++) m[j][i] = 0;
        end
    endfunction

    function automatic void upd(int i);
        for (int j = 0; j < 2; j++) begin
            int u, us, l;
            l = (j == 0) ? 0 : 2;
            u = $signed(res[i]) >>> 8;
            us = (u > 256) ? 256 : (u < -256) ? -256 : u;
            if (us != u) sc[j]++;
            m[j][i] = m[j][i] + ((us - m[j][i]) >>> l);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else begin
            for (int j = 0; j < 2; j++) rd[j] = m[j][state_addr];
            if ((k == -1 || k == 18) && start) begin
                k = 0;
                sc[0] = 0; sc[1] = 0;
            end else begin
                if ((k == -1 || k == 18) && clear)
                    for (int j = 0; j < 2; j++) for (int i = 0; i < 16; i++) m[j][i] = 0;
                k = (k == 18 || k < 0) ? -1 : k + 1;
            end
            if (k >= 0 && k <= 15) pa = k;
            if (k >= 2 && k <= 17) upd(k - 2);
            if (k == 18 && SATEN) begin msat[0] = sc[0]; msat[1] = sc[1]; end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("busy0", int'(busy0), int'(k >= 0 && k <= 17));
        chk("busy2", int'(busy2), int'(k >= 0 && k <= 17));
        chk("done0", int'(done0), int'(k == 18));
        chk("done2", int'(done2), int'(k == 18));
        chk("prod_addr0", int'(pa0), pa);
        chk("prod_addr2", int'(pa2), pa);
        chk("sat_cnt0", int'(sat0), msat[0]);
        chk("sat_cnt2", int'(sat2), msat[1]);
        chk("state_data0", int'($signed(sd0)), rd[0]);
        chk("state_data2", int'($signed(sd2)), rd[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string nm, input int which, input int e0, input int er);
        for (int i = 0; i < 16; i++) begin
            state_addr = 4'(i);
            tick();
            chk($sformatf("%s[%0d]", nm, i), which == 0 ? int'($signed(sd0)) : int'($signed(sd2)),
                i == 0 ? e0 : er);
        end
    endtask

    task automatic set_res_all(input logic [31:0] v);
        for (int i = 0; i < 16; i++) res[i] = v;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // clr_at == 0 raises clear together with start; repulse/clr_at are cycle offsets into the pass
    task automatic run_pass(input int repulse, input int clr_at, input string nm);
        int first, nd;
        first = -1;
        nd = 0;
        start = 1'b1;
        clear = (clr_at == 0);
        tick();
        start = 1'b0;
        clear = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            start = (c == repulse);
            clear = (c == clr_at);
            tick();
            start = 1'b0;
            clear = 1'b0;
            if (done0) begin
                nd++;
                if (first < 0) first = c;
            end
        end
        chk({nm, "_latency"}, first, 18);
        chk({nm, "_done_count"}, nd, 1);
    endtask

    initial begin
        int nd;
        set_res_all(32'h0);
        repeat (2) tick();
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_prod_addr", int'(pa0), 0);
        chk("rst_sat_cnt", int'(sat0), 0);
        chk("rst_state_data", int'(sd2), 0);
        rst_n = 1'b1;
        tick();
        chk_state("rst_state0", 0, 0, 0);

        for (int i = 0; i < 16; i++) res[i] = 32'(i) << 16;
        run_pass(-1, -1, "ramp");
        chk_state("ramp_l0", 0, 0, 256);
        chk_state("ramp_l2", 1, 0, 64);
        chk("ramp_sat", int'(sat0), SATEN ? 14 : 0);

        do_clear();
        set_res_all(32'h0000_8000);
        run_pass(-1, -1, "half1");
        chk_state("half1_l2", 1, 32, 32);
        chk_state("half1_l0", 0, 128, 128);
        chk("half1_sat", int'(sat2), 0);
        run_pass(-1, 0, "half2");
        chk_state("half2_l2", 1, 56, 56);

        do_clear();
        set_res_all(32'hFFFD_0000);
        run_pass(-1, -1, "neg3");
        chk_state("neg3_l2", 1, -64, -64);
        chk_state("neg3_l0", 0, -256, -256);
        chk("neg3_sat", int'(sat2), SATEN ? 16 : 0);

        do_clear();
        set_res_all(32'h0000_8000);
        run_pass(5, -1, "repulse");
        chk_state("repulse_l2", 1, 32, 32);
        run_pass(-1, 3, "runclear");
        chk_state("runclear_l2", 1, 56, 56);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", int'(busy2), 0);
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (done0 || done2) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk_state("abort_l2", 1, 0, 0);
        chk_state("abort_l0", 0, 0, 0);

        run_pass(-1, -1, "refill");
        chk_state("refill_l2", 1, 32, 32);
        do_clear();
        chk_state("idleclear_l2", 1, 0, 0);
        chk_state("idleclear_l0", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
